// File: rtl/tile_renderer.sv
// tile_renderer: serialises 8x8 VRAM tiles (32x24 grid) into a 4-bit palette index, syncs delayed to match
// Ports: clk, reset (async, active-low), xPos/yPos (signed raster position), isActive, hSync, vSync,
//   borderColor (index outside active area), vramAddr/vramRead/vramData (synchronous VRAM read port),
//   pixel (registered palette index), hSyncOut/vSyncOut/activeOut (inputs delayed one clock).
module tile_renderer #(
  parameter logic [13:0] NAME_BASE = 14'h1800,
  parameter logic [13:0] PAT_BASE  = 14'h0000,
  parameter logic [13:0] COL_BASE  = 14'h2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [8:0] xPos,
  input  logic signed [8:0] yPos,
  input  logic              isActive,
  input  logic              hSync,
  input  logic              vSync,
  input  logic [3:0]        borderColor,
  output logic [13:0]       vramAddr,
  output logic              vramRead,
  input  logic [7:0]        vramData,
  output logic [3:0]        pixel,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              activeOut
);
  logic signed [8:0] fcol;
  logic [2:0] ph;
  logic fetch_en, grp_ok;
  logic [7:0] name_reg, pat_reg, col_reg, shifter;
  logic [3:0] fg, bg;
  assign fcol = (xPos + 9'sd8) >>> 3;
  assign ph = xPos[2:0];
  assign fetch_en = !yPos[8] && (yPos < 9'sd192) && !fcol[8] && (fcol < 9'sd32);
  // Reads are registered, so each VRAM byte arrives two cycles after the phase that requests it:
  // name requested ph0 -> captured ph2, pattern requested ph2 -> ph4, colour requested ph3 -> ph5.
  // grp_ok marks a group whose ph0 request was issued, so a reset released mid-group never
  // captures stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vramAddr  <= '0;
      vramRead  <= 1'b0;
      pixel     <= '0;
      hSyncOut  <= 1'b0;
      vSyncOut  <= 1'b0;
      activeOut <= 1'b0;
      grp_ok    <= 1'b0;
      name_reg  <= '0;
      pat_reg   <= '0;
      col_reg   <= '0;
      shifter   <= '0;
      fg        <= '0;
      bg        <= '0;
    end else begin
      hSyncOut  <= hSync;
      vSyncOut  <= vSync;
      activeOut <= isActive;
      pixel     <= isActive ? (shifter[7] ? fg : bg) : borderColor;
      vramRead  <= 1'b0;
      if (ph == 3'd0) begin
        grp_ok <= fetch_en;
        if (fetch_en) begin
          vramRead <= 1'b1;
          vramAddr <= NAME_BASE + {4'b0, yPos[7:3], fcol[4:0]};
        end
      end
      if (grp_ok && ph == 3'd2) begin
        name_reg <= vramData;
        vramRead <= 1'b1;
        vramAddr <= PAT_BASE + {3'b0, vramData, yPos[2:0]};
      end
      if (grp_ok && ph == 3'd3) begin
        vramRead <= 1'b1;
        vramAddr <= COL_BASE + {9'b0, name_reg[7:3]};
      end
      if (grp_ok && ph == 3'd4) pat_reg <= vramData;
      if (grp_ok && ph == 3'd5) col_reg <= vramData;
      if (ph == 3'd7) begin
        shifter <= grp_ok ? pat_reg : 8'h00;
        if (grp_ok) begin
          fg <= col_reg[7:4];
          bg <= col_reg[3:0];
        end
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: directed and reference-model checks of tile_renderer against a VRAM model
module tb_tile_renderer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [8:0] xPos = '0, yPos = '0;
  logic isActive = 1'b0, hSync = 1'b0, vSync = 1'b0;
  logic [3:0] borderColor = 4'hA;
  logic [13:0] vramAddr;
  logic vramRead;
  logic [7:0] vramData = '0;
  logic [3:0] pixel;
  logic hSyncOut, vSyncOut, activeOut;
  int checks = 0, errors = 0;
  logic [7:0] mem [16384];
  logic [3:0] o_pix [320];
  logic o_hs [320], o_vs [320], o_act [320], o_rd [320];
  logic [13:0] o_addr [320];

  tile_renderer dut (
    .clk(clk), .reset(reset), .xPos(xPos), .yPos(yPos), .isActive(isActive),
    .hSync(hSync), .vSync(vSync), .borderColor(borderColor), .vramAddr(vramAddr),
    .vramRead(vramRead), .vramData(vramData), .pixel(pixel), .hSyncOut(hSyncOut),
    .vSyncOut(vSyncOut), .activeOut(activeOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (vramRead) vramData <= mem[vramAddr];

  function automatic logic act_of(int x, int y);
    return x >= 0 && x <= 255 && y >= 0 && y <= 191;
  endfunction

  function automatic logic [3:0] exp_pix(int x, int y);
    logic [7:0] n, p, c;
    if (!act_of(x, y)) return borderColor;
    n = mem[32'h1800 + (y / 8) * 32 + x / 8];
    p = mem[int'(n) * 8 + y % 8];
    c = mem[32'h2000 + int'(n) / 8];
    return p[7 - x % 8] ? c[7:4] : c[3:0];
  endfunction

  task automatic run_line(int y, int xs, int xe, int rst_x);
    for (int x = xs; x <= xe; x++) begin
      xPos = 9'(x);
      yPos = 9'(y);
      isActive = act_of(x, y);
      hSync = x >= 256;
      vSync = y < 0;
      if (x >= rst_x) reset = 1'b1;
      @(posedge clk);
      #1;
      o_pix[x + 32] = pixel;
      o_hs[x + 32] = hSyncOut;
      o_vs[x + 32] = vSyncOut;
      o_act[x + 32] = activeOut;
      o_rd[x + 32] = vramRead;
      o_addr[x + 32] = vramAddr;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      xPos = 9'($urandom);
      yPos = 9'($urandom);
      isActive = 1'($urandom);
      hSync = 1'($urandom);
      vSync = 1'($urandom);
      borderColor = 4'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({pixel, vramRead, vramAddr, hSyncOut, vSyncOut, activeOut} !== 23'd0) begin
        errors++;
        $display("FAIL reset_outs cycle %0d: got pix=%h rd=%b addr=%h hs=%b vs=%b act=%b, need all 0",
                 i, pixel, vramRead, vramAddr, hSyncOut, vSyncOut, activeOut);
      end
    end
    borderColor = 4'hA;
    run_line(50, -24, 263, 100);
    for (int x = 0; x <= 255; x++) begin
      checks++;
      if (o_pix[x + 32] !== (x < 112 ? 4'h0 : exp_pix(x, 50))) begin
        errors++;
        $display("FAIL midline_release x=%0d: got %h need %h", x, o_pix[x + 32],
                 x < 112 ? 4'h0 : exp_pix(x, 50));
      end
    end
  endtask

  task automatic test_tile0;
    logic [3:0] want [8] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    run_line(0, -24, 263, -1000);
    for (int x = 0; x < 8; x++) begin
      checks++;
      if (o_pix[x + 32] !== want[x]) begin
        errors++;
        $display("FAIL tile0_pixel x=%0d: got %h need %h", x, o_pix[x + 32], want[x]);
      end
    end
  endtask

  task automatic test_addresses;
    int nrd = 0;
    run_line(13, -24, 263, -1000);
    for (int x = -8; x <= -1; x++) nrd += int'(o_rd[x + 32]);
    checks++;
    if (nrd != 3) begin
      errors++;
      $display("FAIL addr_read_count: got %0d need 3", nrd);
    end
    checks++;
    if (o_rd[24] !== 1'b1 || o_addr[24] !== 14'h1820) begin
      errors++;
      $display("FAIL addr_name: got rd=%b addr=%h need 1 1820", o_rd[24], o_addr[24]);
    end
    checks++;
    if (o_rd[26] !== 1'b1 || o_addr[26] !== 14'h049D) begin
      errors++;
      $display("FAIL addr_pattern: got rd=%b addr=%h need 1 049d", o_rd[26], o_addr[26]);
    end
    checks++;
    if (o_rd[27] !== 1'b1 || o_addr[27] !== 14'h2012) begin
      errors++;
      $display("FAIL addr_colour: got rd=%b addr=%h need 1 2012", o_rd[27], o_addr[27]);
    end
  endtask

  task automatic test_last_tile;
    run_line(0, -24, 263, -1000);
    for (int x = 248; x <= 263; x++) begin
      checks++;
      if (o_pix[x + 32] !== (x <= 255 ? 4'h7 : 4'hA)) begin
        errors++;
        $display("FAIL last_tile x=%0d: got %h need %h", x, o_pix[x + 32], x <= 255 ? 4'h7 : 4'hA);
      end
      checks++;
      if (o_rd[x + 32] !== 1'b0) begin
        errors++;
        $display("FAIL late_read x=%0d: got %b need 0", x, o_rd[x + 32]);
      end
    end
  endtask

  task automatic test_frame(int ys, int ye, int xs);
    for (int y = ys; y <= ye; y++) begin
      run_line(y, xs, 263, -1000);
      for (int x = xs; x <= 263; x++) begin
        checks++;
        if (o_pix[x + 32] !== exp_pix(x, y)) begin
          errors++;
          $display("FAIL frame_pixel y=%0d x=%0d: got %h need %h", y, x, o_pix[x + 32], exp_pix(x, y));
        end
        checks++;
        if ({o_hs[x + 32], o_vs[x + 32], o_act[x + 32]} !== {x >= 256, y < 0, act_of(x, y)}) begin
          errors++;
          $display("FAIL frame_syncs y=%0d x=%0d: got %b%b%b need %b%b%b", y, x, o_hs[x + 32],
                   o_vs[x + 32], o_act[x + 32], x >= 256, y < 0, act_of(x, y));
        end
        checks++;
        if (o_rd[x + 32] && (y < 0 || y > 191 || x < -8 || x > 247)) begin
          errors++;
          $display("FAIL frame_read y=%0d x=%0d: got read 1 need 0", y, x);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h1800] = 8'h41;
    mem[14'h0208] = 8'b1010_0000;
    mem[14'h2008] = 8'hF1;
    mem[14'h1820] = 8'h93;
    mem[14'h181F] = 8'hC8;
    mem[14'h0640] = 8'hFF;
    mem[14'h2019] = 8'h73;
    test_reset;
    test_tile0;
    test_addresses;
    test_last_tile;
    test_frame(-3, 20, -19);
    test_frame(-2, 193, -24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
